// File: rtl/cla_arb_pkg.sv
// Shared types and defaults for the round-robin CLA adder arbiter.
// rr_pick is the behavioural statement of the grant rule that cla_rr_pick implements structurally.
package cla_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    localparam int CLA_ARB_N_REQ = 4;
    localparam int CLA_ARB_WIDTH = 12;

    // First set request at or above ptr, wrapping modulo n (n <= 16); result is one-hot or zero.
    function automatic logic [15:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int n);
        logic [15:0] gnt;
        logic        found;
        int          idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/cla_12bit.sv
// Carry-lookahead adder built from 4-bit lookahead groups; WIDTH must be a multiple of 4.
// Group generate/propagate terms chain between groups so the carry path is one AND-OR level per group.
module cla_12bit #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_c;
    logic [NG:0]      w_gc;

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_gc[0] = i_cin;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int B = 4 * k;
        logic w_grp_g;
        logic w_grp_p;

        assign w_c[B]   = w_gc[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_gc[k]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);

        assign w_grp_g = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                       | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_grp_p = &w_p[B+3:B];

        assign w_gc[k+1] = w_grp_g | (w_grp_p & w_gc[k]);
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[NG];

endmodule

// File: rtl/cla_rr_pick.sv
// Combinational round-robin picker: rotate requests so the pointer sits at bit 0,
// take the lowest set bit, then rotate the index back.
module cla_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_idx,
    output logic             o_any
);

    localparam logic [ID_W:0] N_VAL = (ID_W + 1)'(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [ID_W-1:0]    w_ofs;
    logic               w_hit;
    logic [ID_W:0]      w_idx_sum;

    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[{1'b0, i_ptr} +: N_REQ];

    // NOTE: every variable assigned in an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        w_hit = 1'b0;
        w_ofs = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_hit = 1'b1;
                w_ofs = ID_W'(j);
            end
        end
    end

    assign w_idx_sum = {1'b0, i_ptr} + {1'b0, w_ofs};
    assign o_gnt_idx = ID_W'((w_idx_sum >= N_VAL) ? (w_idx_sum - N_VAL) : w_idx_sum);
    assign o_gnt     = w_hit ? (N_REQ'(1) << o_gnt_idx) : '0;
    assign o_any     = w_hit;

endmodule

// File: rtl/cla_add_arbiter.sv
// Time-shares one cla_12bit adder among N_REQ requesters with round-robin grants
// and returns an ID-tagged, registered sum on a single valid/ready channel.
module cla_add_arbiter
    import cla_arb_pkg::*;
#(
    parameter int WIDTH = CLA_ARB_WIDTH,
    parameter int N_REQ = CLA_ARB_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_add1,
    input  logic [N_REQ*WIDTH-1:0] i_add2,
    output logic [N_REQ-1:0]       o_gnt,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [WIDTH:0]         o_result,
    input  logic                   i_rsp_ready
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_rsp_id;
    logic [WIDTH:0]   r_result;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [ID_W-1:0]  w_pick_idx;
    logic             w_pick_any;
    logic             w_slot_free;
    logic             w_grant;
    logic [ID_W-1:0]  w_ptr_next;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    cla_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_pick_gnt),
        .o_gnt_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    // A held result may be replaced in the same edge the consumer takes it.
    assign w_slot_free = (r_state == EMPTY) || i_rsp_ready;
    assign w_grant     = w_slot_free && w_pick_any && !i_rst;
    assign o_gnt       = w_grant ? w_pick_gnt : '0;
    assign w_ptr_next  = (w_pick_idx == LAST_IDX) ? '0 : (w_pick_idx + ID_W'(1));

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_op_a = w_op_a | i_add1[k*WIDTH +: WIDTH];
                w_op_b = w_op_b | i_add2[k*WIDTH +: WIDTH];
            end
        end
    end

    cla_12bit #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            EMPTY: if (w_grant) w_next_state = FULL;
            FULL: begin
                if (w_grant)          w_next_state = FULL;
                else if (i_rsp_ready) w_next_state = EMPTY;
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= EMPTY;
            r_ptr    <= '0;
            r_rsp_id <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_result <= {w_cout, w_sum};
                r_rsp_id <= w_pick_idx;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    assign o_rsp_valid = (r_state == FULL);
    assign o_rsp_id    = r_rsp_id;
    assign o_result    = r_result;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed and randomized bench for cla_add_arbiter against a cycle-level reference
// model that applies the round-robin and handshake rules with plain integer arithmetic.
module tb_cla_add_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int IW = 2;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [N-1:0]     i_req;
    logic [N*W-1:0]   i_add1;
    logic [N*W-1:0]   i_add2;
    logic [N-1:0]     o_gnt;
    logic             o_rsp_valid;
    logic [IW-1:0]    o_rsp_id;
    logic [W:0]       o_result;
    logic             i_rsp_ready;

    cla_add_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .ID_W  (IW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_add1      (i_add1),
        .i_add2      (i_add2),
        .o_gnt       (o_gnt),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_result    (o_result),
        .i_rsp_ready (i_rsp_ready)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];

    // Reference model state
    int m_ptr  = 0;
    bit m_full = 1'b0;
    int m_id   = 0;
    int m_res  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check grant, let the edge happen,
    // advance the model, then check the registered response at the next falling edge.
    task automatic step(input logic [N-1:0] req, input logic ready, input logic rst);
        int win;
        int exp_gnt;
        i_req       = req;
        i_rsp_ready = ready;
        i_rst       = rst;
        for (int k = 0; k < N; k++) begin
            i_add1[k*W +: W] = opa[k];
            i_add2[k*W +: W] = opb[k];
        end
        #1;
        win = -1;
        if (!rst && (!m_full || ready)) begin
            for (int i = 0; i < N; i++) begin
                if (win < 0 && req[(m_ptr + i) % N]) win = (m_ptr + i) % N;
            end
        end
        exp_gnt = (win >= 0) ? (1 << win) : 0;
        check("gnt", 32'(o_gnt), 32'(exp_gnt));
        @(posedge i_clk);
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            m_id   = 0;
            m_res  = 0;
        end else if (win >= 0) begin
            m_full = 1'b1;
            m_res  = int'(opa[win]) + int'(opb[win]);
            m_id   = win;
            m_ptr  = (win + 1) % N;
        end else if (ready) begin
            m_full = 1'b0;
        end
        @(negedge i_clk);
        check("rsp_valid", 32'(o_rsp_valid), 32'(m_full));
        check("rsp_id", 32'(o_rsp_id), 32'(m_id));
        check("result", 32'(o_result), 32'(m_res));
    endtask

    task automatic set_all_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < N; k++) begin
            opa[k] = a;
            opb[k] = b;
        end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req       = '0;
        i_rsp_ready = 1'b0;
        i_add1      = '0;
        i_add2      = '0;
        set_all_ops('0, '0);

        // Reset with requests asserted: grant must stay low, outputs cleared
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        check("reset_valid", 32'(o_rsp_valid), 32'd0);
        check("reset_result", 32'(o_result), 32'd0);

        // Single request with carry into the MSB
        opa[0] = 12'hFFF;
        opb[0] = 12'h001;
        step(4'b0001, 1'b1, 1'b0);
        check("single_result", 32'(o_result), 32'h1000);
        check("single_id", 32'(o_rsp_id), 32'd0);
        step(4'b0000, 1'b1, 1'b0);

        // All four requesting, back-to-back results, starting from a fresh pointer
        step(4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) begin
            opa[k] = W'(k);
            opb[k] = 12'd8;
        end
        for (int c = 0; c < 6; c++) step(4'b1111, 1'b1, 1'b0);
        check("rr_last_id", 32'(o_rsp_id), 32'd1);

        // Backpressure: grant to 0 leaves the pointer at 1, then stall five cycles
        step(4'b0001, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) step(4'b0110, 1'b0, 1'b0);
        check("bp_held_result", 32'(o_result), 32'd8);
        step(4'b0110, 1'b1, 1'b0);
        check("bp_release_id", 32'(o_rsp_id), 32'd1);

        // Pointer wrap between requesters 3 and 0
        step(4'b1000, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b1001, 1'b1, 1'b0);
        check("wrap_id", 32'(o_rsp_id), 32'd0);

        // Operand extremes
        opa[2] = 12'hFFF;
        opb[2] = 12'hFFF;
        step(4'b0100, 1'b1, 1'b0);
        check("max_result", 32'(o_result), 32'h1FFE);
        opa[2] = 12'h000;
        opb[2] = 12'h000;
        step(4'b0100, 1'b1, 1'b0);
        check("zero_result", 32'(o_result), 32'h0);

        // Reset while FULL with requests pending
        set_all_ops(12'h123, 12'h456);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        check("rst_mid_valid", 32'(o_rsp_valid), 32'd0);
        step(4'b1111, 1'b1, 1'b0);
        check("rst_restart_id", 32'(o_rsp_id), 32'd0);

        // Randomized traffic including withdrawn requests and occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                opa[k] = W'($urandom);
                opb[k] = W'($urandom);
            end
            step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_add_arbiter.md
# cla_add_arbiter

Round-robin arbiter and sequencer that time-shares one `cla_12bit` adder among `N_REQ` requesters. It performs one addition per cycle and returns a registered, ID-tagged result on a single valid/ready response channel. The block sits between the operand-producing request ports and downstream consumers in the batch adder test harness.

## Interface
- `WIDTH`, 12, operand width; passed unchanged to the `cla_12bit` instance.
- `N_REQ`, 4, number of requesters; legal range 2..16.
- `ID_W`, `$clog2(N_REQ)`, width of the response ID tag.

- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  N_REQ  per-requester request; held high with operands stable until granted.
- `i_add1`  in  N_REQ*WIDTH  flattened operand A; slice k = `[k*WIDTH +: WIDTH]`.
- `i_add2`  in  N_REQ*WIDTH  flattened operand B, same slicing as `i_add1`.
- `o_gnt`  out  N_REQ  one-hot grant pulse; combinational; operands are consumed in that cycle.
- `o_rsp_valid`  out  1  response register holds a result.
- `o_rsp_id`  out  ID_W  index of the requester that owns the result.
- `o_result`  out  WIDTH+1  registered sum; the MSB is the carry-out.
- `i_rsp_ready`  in  1  consumer accepts the response this cycle.

## Operation
- FSM has two states, held in `r_state`:
  - EMPTY: response register free.
  - FULL: result held, waiting for the consumer.
- Define `slot_free = (state==EMPTY) || i_rsp_ready`.
- Grant: when `slot_free && |i_req && !i_rst`, exactly one bit of `o_gnt` is set. It is the first requester at or above `r_ptr`, searching upward with wrap modulo `N_REQ`. Otherwise `o_gnt = 0`.
- On a grant to k:
  - The slice-k operands are muxed into `cla_12bit`.
  - At the next edge, `o_result`, `o_rsp_id` and `o_rsp_valid=1` are loaded and the state goes to FULL.
  - `r_ptr` becomes `(k+1) mod N_REQ`.
- Response handshake:
  - FULL with `i_rsp_ready=1` and no grant → EMPTY, and `o_rsp_valid` drops.
  - FULL with `i_rsp_ready=1` and a grant → stay FULL; the new result replaces the old one in the same edge, giving back-to-back throughput.
  - FULL with `i_rsp_ready=0` → `o_result` and `o_rsp_id` are held bit-stable and no grant is issued.
- EMPTY with a grant → FULL.
- Arithmetic: `o_result = i_add1[k] + i_add2[k]`, unsigned, WIDTH+1 bits, carry-in 0, no overflow possible.
- `r_ptr` only moves on a grant; requests that are not granted do not affect it.
- Requester protocol: dropping `i_req[k]` before its grant is legal, and the request is simply withdrawn. Operand changes while the request is still pending are sampled only in the grant cycle.
- Reset values, with `i_rst` high for at least one edge:
  - `r_state=EMPTY`, `r_ptr=0`, `o_rsp_valid=0`, `o_rsp_id=0`, `o_result=0`.
  - `o_gnt` is forced to 0 during any cycle in which `i_rst` is high.
  - Reset mid-FULL discards the held result with no response.

## Timing
- Latency: 1 cycle from the grant cycle to `o_rsp_valid`.
- Throughput: 1 result per cycle while `i_rsp_ready` stays high.
- `o_gnt` has combinational paths from `i_req`, `i_rsp_ready`, `i_rst` and `r_ptr`.
- All other outputs come straight from flops.
- Critical path: `r_ptr` → priority pick → operand mux → `cla_12bit` carry chain → `o_result` D input. This path must close in one cycle at WIDTH=12.
- Fairness: with all requesters asserting continuously and `i_rsp_ready=1`, each requester is granted exactly once every `N_REQ` cycles.

## Structure
- Package `cla_arb_pkg`:
  - state enum {EMPTY, FULL};
  - default constants `CLA_ARB_N_REQ=4` and `CLA_ARB_WIDTH=12`;
  - function `rr_pick(req, ptr)` returning a one-hot vector.
- Sub-module `cla_rr_pick` (parameter `N_REQ`):
  - purely combinational rotate / priority-encode / rotate-back;
  - outputs `gnt` one-hot plus `gnt_idx`.
- One `cla_12bit #(.WIDTH(WIDTH))` instance handles the add. No other arithmetic is in the block.

## Test plan
- Single request: after reset, `i_req=4'b0001`, A0=12'hFFF, B0=12'h001 → `o_gnt=4'b0001` that cycle. Next cycle: `o_rsp_valid=1`, `o_rsp_id=0`, `o_result=13'h1000`.
- All four requesting, `i_rsp_ready=1`, Ak=k, Bk=8 → grant order 0,1,2,3,0,1 in consecutive cycles, and results 8,9,10,11 with matching IDs back-to-back.
- Backpressure: FULL with `i_rsp_ready=0` for 5 cycles and `i_req=4'b0110` → `o_gnt=0` and result/ID stable. When ready rises, requester 1 is granted in the same cycle and the new result appears the next cycle.
- Pointer wrap: last grant to 3, then `i_req=4'b1001` → grant 0, then 3, then 0.
- Maximum operands: A=B=12'hFFF → `o_result=13'h1FFE`. Zero operands → 13'h000.
- Reset mid-operation: FULL with requests pending, assert `i_rst` for 1 cycle → `o_gnt=0` during reset. Next cycle: `o_rsp_valid=0`, `o_result=0`, and arbitration restarts at requester 0.
